flux_fifo: RTL

FLUX_FIFO -- requirements
Module: flux_fifo

---
 rtl/flux_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/flux_fifo.sv
// Multi-lane, multi-flux FIFO: each lane sorts incoming words by tag into FLUX
// queues and drains one selected queue at a time. Define FLUX_FIFO_ERR_EN to add err.
module flux_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int PORTS      = 2,
  parameter int DEPTH      = 4,
  localparam int TAGW      = $clog2(FLUX),
  localparam int WIDTH     = DATA_WIDTH + TAGW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH*PORTS-1:0]   din,
  input  logic                     write,
  output logic [FLUX*PORTS-1:0]    full,
  output logic [WIDTH*PORTS-1:0]   dout,
  input  logic [FLUX*PORTS-1:0]    read,
`ifdef FLUX_FIFO_ERR_EN
  output logic [2*PORTS-1:0]       err,
`endif
  output logic [FLUX*PORTS-1:0]    empty
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  // Valid/ready: a word is taken when write=1 and its target queue is not full;
  // a word leaves when the selected flux's read bit is 1 and that queue is not empty.

  function automatic logic [TAGW-1:0] wrap_idx(input int v);
    return TAGW'(v % FLUX);
  endfunction

  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    logic [WIDTH-1:0] wdata;
    logic [TAGW-1:0]  wtag;
    logic [PTRW-1:0]  rd_ptr [FLUX];
    logic [PTRW-1:0]  wr_ptr [FLUX];
    logic [CNTW-1:0]  cnt [FLUX];
    logic [CNTW-1:0]  cnt_nxt [FLUX];
    logic [FLUX-1:0]  q_full, q_empty, push, pop;
    logic [TAGW-1:0]  sel, sel_nxt;
    logic             found;
    logic [WIDTH-1:0] mem [FLUX][DEPTH];

    assign wdata = din[p*WIDTH +: WIDTH];
    assign wtag  = wdata[WIDTH-1 -: TAGW];

    always_comb begin
      q_full  = '0;
      q_empty = '0;
      push    = '0;
      pop     = '0;
      for (int f = 0; f < FLUX; f++) begin
        q_full[f]  = (cnt[f] == CNTW'(DEPTH));
        q_empty[f] = (cnt[f] == '0);
        push[f]    = write && (wtag == TAGW'(f)) && (cnt[f] != CNTW'(DEPTH));
        pop[f]     = (sel == TAGW'(f)) && read[p*FLUX+f] && (cnt[f] != '0);
        cnt_nxt[f] = cnt[f] + CNTW'(push[f]) - CNTW'(pop[f]);
      end
    end

    // Round-robin: after a pop the search starts one past the current flux.
    always_comb begin
      sel_nxt = sel;
      found   = 1'b0;
      for (int k = 0; k < FLUX; k++) begin
        if (!found && cnt_nxt[wrap_idx(int'(sel) + int'(|pop) + k)] != '0) begin
          sel_nxt = wrap_idx(int'(sel) + int'(|pop) + k);
          found   = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int f = 0; f < FLUX; f++) begin
        if (push[f]) mem[f][wr_ptr[f]] <= wdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sel <= '0;
        for (int f = 0; f < FLUX; f++) begin
          rd_ptr[f] <= '0;
          wr_ptr[f] <= '0;
          cnt[f]    <= '0;
        end
      end else begin
        sel <= sel_nxt;
        for (int f = 0; f < FLUX; f++) begin
          cnt[f] <= cnt_nxt[f];
          if (push[f]) wr_ptr[f] <= wr_ptr[f] + PTRW'(1);
          if (pop[f])  rd_ptr[f] <= rd_ptr[f] + PTRW'(1);
        end
      end
    end

    assign full[p*FLUX +: FLUX]  = q_full;
    assign empty[p*FLUX +: FLUX] = q_empty;
    assign dout[p*WIDTH +: WIDTH] = q_empty[sel] ? '0 : mem[sel][rd_ptr[sel]];

`ifdef FLUX_FIFO_ERR_EN
    logic [1:0] err_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        err_q <= '0;
      end else begin
        if (write && !(|push))                   err_q[0] <= 1'b1;
        if (|(read[p*FLUX +: FLUX] & ~pop))      err_q[1] <= 1'b1;
      end
    end
    assign err[2*p +: 2] = err_q;
`endif
  end

endmodule
